// File: rtl/uart_sched_pkg.sv
// Shared types and default parameters for the UART TX scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    localparam int unsigned DEFAULT_DEPTH   = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a combinational head read.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [LW-1:0]    level_d;

    // Full/empty gating uses the registered flags, so a same-cycle pop never rescues a push.
    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        level_d = level + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_d;
            full  <= (level_d == LW'(DEPTH));
            empty <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign rdata_c = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers core UART stores and hands bytes to the UART TX via a start/busy handshake.
// Optional handshake watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   cpu_clk,
    input  logic                   reset,
    input  logic                   wr_req,
    input  logic [7:0]             wr_data,
    input  logic                   clr_flags,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   tx_err
);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_check
        $error("uart_tx_scheduler: DEPTH must be a power of two in 2..64 and TIMEOUT nonzero");
    end

    sched_state_e state_q;
    sched_state_e state_d;
    logic         tx_start_d;
    logic [7:0]   tx_data_d;
    logic         ovf_d;
    logic         pop;
    logic [7:0]   head_c;
    logic         timeout_c;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (cpu_clk),
        .rst     (reset),
        .push    (wr_req),
        .pop     (pop),
        .wdata   (wr_data),
        .rdata_c (head_c),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Next-state and registered-output logic; tx_data is captured on the way into LOAD
    // so it is already valid while tx_start is high.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        pop        = 1'b0;
        ovf_d      = ovf;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d    = LOAD;
                    tx_start_d = 1'b1;
                    tx_data_d  = head_c;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (timeout_c) state_d = IDLE;

        if (clr_flags)       ovf_d = 1'b0;
        if (wr_req && full)  ovf_d = 1'b1;
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            ovf      <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            ovf      <= ovf_d;
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt_q;
    logic          in_wait_c;
    logic          tx_err_q;
    logic          tx_err_d;

    always_comb begin
        in_wait_c = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
        timeout_c = in_wait_c && (tmo_cnt_q == CW'(TIMEOUT - 1));
        tx_err_d  = tx_err_q;
        if (clr_flags) tx_err_d = 1'b0;
        if (timeout_c) tx_err_d = 1'b1;
    end

    // Counter restarts on every state change, so each wait state gets a full budget.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tx_err_q  <= 1'b0;
        end else begin
            if (state_d != state_q) tmo_cnt_q <= '0;
            else if (in_wait_c)     tmo_cnt_q <= tmo_cnt_q + CW'(1);
            tx_err_q <= tx_err_d;
        end
    end

    assign tx_err = tx_err_q;
`else
    assign timeout_c = 1'b0;
    assign tx_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (DEPTH=8, TIMEOUT=20).
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    logic       cpu_clk;
    logic       reset;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       clr_flags;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       ovf;
    logic       tx_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q[$];
    bit unstable;

    uart_tx_scheduler #(.DEPTH(8), .TIMEOUT(20)) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .clr_flags (clr_flags),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .ovf       (ovf),
        .tx_err    (tx_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; wr_req = 1'b0; wr_data = 8'h00; clr_flags = 1'b0; tx_busy = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    // Simple UART model: answers each start pulse with busy_len busy cycles.
    task automatic serve(input int n, input int busy_len, input int budget);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < budget) begin
            step(); cyc++;
            if (tx_start === 1'b1) begin
                rx_q.push_back(tx_data); seen++;
                tx_busy = 1'b1;
                for (int k = 0; k < busy_len; k++) begin
                    step();
                    if (tx_data !== rx_q[rx_q.size()-1]) unstable = 1'b1;
                end
                tx_busy = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 1'b0; wr_data = 8'h00; clr_flags = 1'b0; tx_busy = 1'b0;
        #3;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (ovf !== 1'b0 || tx_err !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b err=%b want 0 0", ovf, tx_err); end
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        int starts = 0;
        apply_reset();
        wr_req = 1'b1; wr_data = 8'h41;
        step();
        wr_req = 1'b0;
        checks++; if (empty !== 1'b0 || level !== 4'd1) begin errors++; $display("FAIL single_push got empty=%b level=%0d want 0 1", empty, level); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %b want 0", tx_start); end
        step();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL single_start got start=%b data=%h want 1 41", tx_start, tx_data); end
        tx_busy = 1'b1;
        step();
        checks++; if (tx_start !== 1'b0 || level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_pop got start=%b level=%0d empty=%b want 0 0 1", tx_start, level, empty); end
        for (int i = 0; i < 9; i++) begin step(); if (tx_start) starts++; end
        tx_busy = 1'b0;
        step(); step();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL single_idle got %0d want %0d", dut.state_q, IDLE); end
        for (int i = 0; i < 5; i++) begin step(); if (tx_start) starts++; end
        checks++; if (starts != 0 || tx_data !== 8'h41) begin errors++; $display("FAIL single_after got starts=%0d data=%h want 0 41", starts, tx_data); end
    endtask

    task automatic test_burst_fill();
        int starts = 0;
        int peak = 0;
        bit full_seen = 1'b0;
        bit order_ok = 1'b1;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            wr_req = 1'b1; wr_data = 8'(i);
            step();
            if (tx_start) starts++;
            if (int'(level) > peak) peak = int'(level);
            if (full) full_seen = 1'b1;
        end
        checks++; if (peak != 7 || full_seen) begin errors++; $display("FAIL burst_peak got peak=%0d full_seen=%b want 7 0", peak, full_seen); end
        wr_data = 8'h08;
        step();
        wr_req = 1'b0;
        checks++; if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL burst_ninth got level=%0d full=%b ovf=%b want 8 1 0", level, full, ovf); end
        checks++; if (starts != 1 || tx_data !== 8'h00 || dut.state_q !== WAIT_BUSY) begin errors++; $display("FAIL burst_stall got starts=%0d data=%h state=%0d want 1 00 %0d", starts, tx_data, dut.state_q, WAIT_BUSY); end
        tx_busy = 1'b1;
        step();
        tx_busy = 1'b0;
        rx_q.delete(); unstable = 1'b0;
        serve(8, 2, 200);
        for (int i = 0; i < 8; i++) if (i >= rx_q.size() || rx_q[i] !== 8'(i + 1)) order_ok = 1'b0;
        checks++; if (!order_ok || rx_q.size() != 8) begin errors++; $display("FAIL burst_order got count=%0d in_order=%b want 8 1", rx_q.size(), order_ok); end
        checks++; if (empty !== 1'b1 || unstable) begin errors++; $display("FAIL burst_drain got empty=%b unstable=%b want 1 0", empty, unstable); end
    endtask

    task automatic test_overflow();
        bit ok;
        bit order_ok = 1'b1;
        int starts = 0;
        apply_reset();
        wr_req = 1'b1; wr_data = 8'hA0;
        step();
        wr_req = 1'b0;
        wait_start(10, ok);
        checks++; if (!ok || tx_data !== 8'hA0) begin errors++; $display("FAIL ovf_first got seen=%b data=%h want 1 a0", ok, tx_data); end
        tx_busy = 1'b1;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            wr_req = 1'b1; wr_data = 8'hB0 + 8'(i); clr_flags = (i == 8);
            if (i == 8) begin
                checks++; if (full !== 1'b1 || level !== 4'd8 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_full got full=%b level=%0d ovf=%b want 1 8 0", full, level, ovf); end
            end
            step();
            if (i == 8) begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", ovf); end
            end
        end
        wr_req = 1'b0; clr_flags = 1'b0;
        checks++; if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold got level=%0d full=%b ovf=%b want 8 1 1", level, full, ovf); end
        tx_busy = 1'b0;
        rx_q.delete(); unstable = 1'b0;
        serve(8, 3, 300);
        for (int i = 0; i < 8; i++) if (i >= rx_q.size() || rx_q[i] !== 8'hB0 + 8'(i)) order_ok = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); if (tx_start) starts++; end
        checks++; if (!order_ok || rx_q.size() != 8 || starts != 0) begin errors++; $display("FAIL ovf_order got count=%0d in_order=%b extra=%0d want 8 1 0", rx_q.size(), order_ok, starts); end
        checks++; if (ovf !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL ovf_sticky got ovf=%b empty=%b want 1 1", ovf, empty); end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        bit order_ok;
        apply_reset();
        wr_req = 1'b1; wr_data = 8'hD0;
        step();
        wr_req = 1'b0;
        wait_start(10, ok);
        tx_busy = 1'b1;
        step(); step();
        for (int i = 0; i < 3; i++) begin wr_req = 1'b1; wr_data = 8'hC0 + 8'(i); step(); end
        wr_req = 1'b0;
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL simul_setup got level=%0d want 3", level); end
        tx_busy = 1'b0;
        wait_start(10, ok);
        checks++; if (!ok || tx_data !== 8'hC0 || level !== 4'd3) begin errors++; $display("FAIL simul_load got seen=%b data=%h level=%0d want 1 c0 3", ok, tx_data, level); end
        wr_req = 1'b1; wr_data = 8'hC3; tx_busy = 1'b1;
        step();
        wr_req = 1'b0;
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL simul_level got %0d want 3", level); end
        step(); step();
        tx_busy = 1'b0;
        rx_q.delete(); unstable = 1'b0;
        serve(3, 2, 200);
        order_ok = (rx_q.size() == 3);
        for (int i = 0; i < 3 && order_ok; i++) if (rx_q[i] !== 8'hC1 + 8'(i)) order_ok = 1'b0;
        checks++; if (!order_ok || unstable) begin errors++; $display("FAIL simul_order got count=%0d in_order=%b unstable=%b want 3 1 0", rx_q.size(), order_ok, unstable); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int starts = 0;
        apply_reset();
        wr_req = 1'b1; wr_data = 8'hE0;
        step();
        wr_req = 1'b0;
        wait_start(10, ok);
        tx_busy = 1'b1;
        step(); step();
        for (int i = 0; i < 4; i++) begin wr_req = 1'b1; wr_data = 8'hE1 + 8'(i); step(); end
        wr_req = 1'b0;
        checks++; if (level !== 4'd4 || dut.state_q !== WAIT_DONE) begin errors++; $display("FAIL mid_setup got level=%0d state=%0d want 4 %0d", level, dut.state_q, WAIT_DONE); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || level !== 4'd0) begin errors++; $display("FAIL mid_async got start=%b data=%h level=%0d want 0 00 0", tx_start, tx_data, level); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL mid_flags got empty=%b full=%b state=%0d want 1 0 %0d", empty, full, dut.state_q, IDLE); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); if (tx_start) starts++; end
        tx_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin step(); if (tx_start) starts++; end
        checks++; if (starts != 0 || empty !== 1'b1) begin errors++; $display("FAIL mid_after got starts=%0d empty=%b want 0 1", starts, empty); end
    endtask

`ifdef UART_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit early = 1'b0;
        apply_reset();
        wr_req = 1'b1; wr_data = 8'hF0; step();
        wr_data = 8'hF1; step();
        wr_req = 1'b0;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hF0) begin errors++; $display("FAIL tmo_first got start=%b data=%h want 1 f0", tx_start, tx_data); end
        step();
        for (int i = 1; i < 20; i++) begin step(); if (tx_err) early = 1'b1; end
        checks++; if (early) begin errors++; $display("FAIL tmo_early got err_before_20=1 want 0"); end
        step();
        checks++; if (tx_err !== 1'b1) begin errors++; $display("FAIL tmo_set got %b want 1", tx_err); end
        step();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hF1) begin errors++; $display("FAIL tmo_next got start=%b data=%h want 1 f1", tx_start, tx_data); end
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", tx_err); end
        ok = 1'b1;
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        bit err_seen = 1'b0;
        int starts = 0;
        apply_reset();
        wr_req = 1'b1; wr_data = 8'h55;
        step();
        wr_req = 1'b0;
        wait_start(10, ok);
        for (int i = 0; i < 40; i++) begin step(); if (tx_start) starts++; if (tx_err) err_seen = 1'b1; end
        checks++; if (!ok || err_seen || starts != 0) begin errors++; $display("FAIL notmo_stall got seen=%b err=%b starts=%0d want 1 0 0", ok, err_seen, starts); end
        checks++; if (dut.state_q !== WAIT_BUSY) begin errors++; $display("FAIL notmo_state got %0d want %0d", dut.state_q, WAIT_BUSY); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst_fill();
        test_overflow();
        test_simultaneous();
        test_reset_midframe();
`ifdef UART_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
